// File: rtl/sdram_arbiter_pkg.sv
// Shared types and helpers for the SDRAM user-port arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One-hot decode of a requester index; callers cast down to NUM_REQ bits.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and SDRAM-controller-side signals of the arbiter.
interface sdram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = sdram_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W  = sdram_arb_pkg::DATA_W_DEF
);
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]              req_readdata;
  logic [NUM_REQ-1:0]             req_finished;
  logic [NUM_REQ-1:0]             grant;
  logic                           sdram_read;
  logic                           sdram_write;
  logic [ADDR_W-1:0]              sdram_addr;
  logic [DATA_W-1:0]              sdram_writedata;
  logic [DATA_W-1:0]              sdram_readdata;
  logic                           sdram_finished;
  logic                           timeout_err;

  modport slave (
    input  req_read, req_write, req_addr, req_writedata,
    input  sdram_readdata, sdram_finished,
    output req_readdata, req_finished, grant,
    output sdram_read, sdram_write, sdram_addr, sdram_writedata, timeout_err
  );

  modport master (
    output req_read, req_write, req_addr, req_writedata,
    output sdram_readdata, sdram_finished,
    input  req_readdata, req_finished, grant,
    input  sdram_read, sdram_write, sdram_addr, sdram_writedata, timeout_err
  );
endinterface

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin finder: first pending index after 'last', wrapping.
module rr_picker #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             hit_s;

  // Scan last+1 .. last+NUM_REQ (mod NUM_REQ) and keep the first hit.
  always_comb begin
    valid      = 1'b0;
    idx        = '0;
    cand_s     = 32'sd0;
    cand_idx_s = '0;
    hit_s      = 1'b0;
    for (int k = 32'sd1; k <= NUM_REQ; k++) begin
      cand_s     = (int'(last) + k) % NUM_REQ;
      cand_idx_s = IDX_W'(cand_s);
      hit_s      = !valid && pending[cand_idx_s];
      idx        = hit_s ? cand_idx_s : idx;
      valid      = valid | hit_s;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM user port; command latched at grant.
// Optional watchdog abort built when ARB_TIMEOUT_EN is defined.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input logic            i_clk,
  input logic            i_rst_n,
  sdram_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_r;
  arb_state_e          state_s;
  logic [IDX_W-1:0]    last_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic [ADDR_W-1:0]   cmd_addr_r;
  logic [DATA_W-1:0]   cmd_wdata_r;
  logic                cmd_is_write_r;
  logic [NUM_REQ-1:0]  pending_s;
  logic                pick_valid_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                load_s;
  logic                done_s;
  logic                timeout_s;

  assign pending_s = bus.req_read | bus.req_write;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .pending (pending_s),
    .last    (last_r),
    .valid   (pick_valid_s),
    .idx     (pick_idx_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;

  // Watchdog: cleared at grant, counts every BUSY cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= '0;
    end else if (load_s) begin
      cnt_r <= '0;
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A completion arriving in the limit cycle takes priority over the abort.
  assign timeout_s = (state_r == BUSY) && (cnt_r == CNT_W'(TIMEOUT - 1)) && !bus.sdram_finished;
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode with grant-load and release strobes.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s = BUSY;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.sdram_finished || timeout_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Grant, round-robin pointer and the latched command; read+write counts as write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_r        <= '0;
      last_r         <= IDX_W'(NUM_REQ - 1);
      cmd_addr_r     <= '0;
      cmd_wdata_r    <= '0;
      cmd_is_write_r <= 1'b0;
    end else if (load_s) begin
      grant_r        <= NUM_REQ'(onehot(3'(pick_idx_s)));
      last_r         <= pick_idx_s;
      cmd_addr_r     <= bus.req_addr[pick_idx_s];
      cmd_wdata_r    <= bus.req_writedata[pick_idx_s];
      cmd_is_write_r <= bus.req_write[pick_idx_s];
    end else if (done_s) begin
      grant_r        <= '0;
    end else begin
      grant_r        <= grant_r;
    end
  end

  // Completion is routed to the owner only while a transaction is open.
  always_comb begin
    if ((state_r == BUSY) && bus.sdram_finished) begin
      bus.req_finished = grant_r;
    end else begin
      bus.req_finished = '0;
    end
  end

  assign bus.grant           = grant_r;
  assign bus.sdram_read      = (state_r == BUSY) && !cmd_is_write_r;
  assign bus.sdram_write     = (state_r == BUSY) && cmd_is_write_r;
  assign bus.sdram_addr      = cmd_addr_r;
  assign bus.sdram_writedata = cmd_wdata_r;
  assign bus.req_readdata    = bus.sdram_readdata;
  assign bus.timeout_err     = timeout_s;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed, table-driven bench for sdram_arbiter (3 requesters, TIMEOUT=8).
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int NR = 3;
  localparam int AW = 23;
  localparam int DW = 32;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  sdram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic        fin;
    logic [31:0] rdata;
    logic [2:0]  e_grant;
    logic        e_rd;
    logic        e_wr;
    logic [22:0] e_addr;
    logic [2:0]  e_fin;
  } vec_t;

  vec_t vt[20];

  initial begin
    // single read, round-robin (req 2 writes), finished in IDLE, read+write = write
    vt[0]  = '{3'b001, 3'b000, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000000, 3'b000};
    vt[1]  = '{3'b001, 3'b000, 1'b0, 32'h0,        3'b001, 1'b1, 1'b0, 23'h000100, 3'b000};
    vt[2]  = '{3'b001, 3'b000, 1'b0, 32'h0,        3'b001, 1'b1, 1'b0, 23'h000100, 3'b000};
    vt[3]  = '{3'b001, 3'b000, 1'b1, 32'hDEADBEEF, 3'b001, 1'b1, 1'b0, 23'h000100, 3'b001};
    vt[4]  = '{3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000100, 3'b000};
    vt[5]  = '{3'b011, 3'b100, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000100, 3'b000};
    vt[6]  = '{3'b011, 3'b100, 1'b0, 32'h0,        3'b010, 1'b1, 1'b0, 23'h000200, 3'b000};
    vt[7]  = '{3'b011, 3'b100, 1'b1, 32'h11111111, 3'b010, 1'b1, 1'b0, 23'h000200, 3'b010};
    vt[8]  = '{3'b011, 3'b100, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000200, 3'b000};
    vt[9]  = '{3'b011, 3'b100, 1'b0, 32'h0,        3'b100, 1'b0, 1'b1, 23'h000300, 3'b000};
    vt[10] = '{3'b011, 3'b100, 1'b1, 32'h22222222, 3'b100, 1'b0, 1'b1, 23'h000300, 3'b100};
    vt[11] = '{3'b011, 3'b100, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000300, 3'b000};
    vt[12] = '{3'b011, 3'b100, 1'b0, 32'h0,        3'b001, 1'b1, 1'b0, 23'h000100, 3'b000};
    vt[13] = '{3'b011, 3'b100, 1'b1, 32'h33333333, 3'b001, 1'b1, 1'b0, 23'h000100, 3'b001};
    vt[14] = '{3'b000, 3'b000, 1'b1, 32'hCAFEF00D, 3'b000, 1'b0, 1'b0, 23'h000100, 3'b000};
    vt[15] = '{3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000100, 3'b000};
    vt[16] = '{3'b010, 3'b010, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000100, 3'b000};
    vt[17] = '{3'b010, 3'b010, 1'b0, 32'h0,        3'b010, 1'b0, 1'b1, 23'h000200, 3'b000};
    vt[18] = '{3'b010, 3'b010, 1'b1, 32'h44444444, 3'b010, 1'b0, 1'b1, 23'h000200, 3'b010};
    vt[19] = '{3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 23'h000200, 3'b000};

    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_addr[0]    = 23'h000100;
    bus.req_addr[1]    = 23'h000200;
    bus.req_addr[2]    = 23'h000300;
    bus.req_writedata[0] = 32'hAAAA0000;
    bus.req_writedata[1] = 32'hAAAA0001;
    bus.req_writedata[2] = 32'hAAAA0002;
    bus.sdram_readdata = '0;
    bus.sdram_finished = 1'b0;

    // reset state
    #12;
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_read", 64'(bus.sdram_read), 64'h0);
    chk("rst_write", 64'(bus.sdram_write), 64'h0);
    chk("rst_addr", 64'(bus.sdram_addr), 64'h0);
    chk("rst_wdata", 64'(bus.sdram_writedata), 64'h0);
    chk("rst_fin", 64'(bus.req_finished), 64'h0);
    chk("rst_terr", 64'(bus.timeout_err), 64'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.req_read       = vt[i].rd;
      bus.req_write      = vt[i].wr;
      bus.sdram_finished = vt[i].fin;
      bus.sdram_readdata = vt[i].rdata;
      #2;
      chk($sformatf("v%0d_grant", i), 64'(bus.grant), 64'(vt[i].e_grant));
      chk($sformatf("v%0d_rd", i), 64'(bus.sdram_read), 64'(vt[i].e_rd));
      chk($sformatf("v%0d_wr", i), 64'(bus.sdram_write), 64'(vt[i].e_wr));
      chk($sformatf("v%0d_addr", i), 64'(bus.sdram_addr), 64'(vt[i].e_addr));
      chk($sformatf("v%0d_fin", i), 64'(bus.req_finished), 64'(vt[i].e_fin));
      chk($sformatf("v%0d_rdata", i), 64'(bus.req_readdata), 64'(vt[i].rdata));
      chk($sformatf("v%0d_terr", i), 64'(bus.timeout_err), 64'h0);
    end

    // write latching: inputs change during BUSY, command must hold
    cyc();
    bus.req_addr[2]      = 23'h7FFFFF;
    bus.req_writedata[2] = 32'h12345678;
    bus.req_write        = 3'b100;
    #2;
    chk("wl_idle", 64'(bus.grant), 64'h0);
    cyc();
    bus.req_addr[2]      = 23'h000000;
    bus.req_writedata[2] = 32'h00000000;
    #2;
    chk("wl_grant", 64'(bus.grant), 64'h4);
    for (int i = 0; i < 3; i++) begin
      chk("wl_write", 64'(bus.sdram_write), 64'h1);
      chk("wl_addr", 64'(bus.sdram_addr), 64'h7FFFFF);
      chk("wl_wdata", 64'(bus.sdram_writedata), 64'h12345678);
      cyc();
      #2;
    end
    bus.sdram_finished = 1'b1;
    #1;
    chk("wl_fin", 64'(bus.req_finished), 64'h4);
    chk("wl_addr_end", 64'(bus.sdram_addr), 64'h7FFFFF);
    cyc();
    bus.sdram_finished = 1'b0;
    bus.req_write      = 3'b000;
    #2;
    chk("wl_release", 64'(bus.grant), 64'h0);

    // abort: requester 0 drops read while BUSY
    cyc();
    bus.req_read = 3'b001;
    #2;
    cyc();
    bus.req_read = 3'b000;
    #2;
    chk("ab_grant", 64'(bus.grant), 64'h1);
    chk("ab_read1", 64'(bus.sdram_read), 64'h1);
    cyc();
    #2;
    chk("ab_read2", 64'(bus.sdram_read), 64'h1);
    cyc();
    bus.sdram_finished = 1'b1;
    #2;
    chk("ab_fin", 64'(bus.req_finished), 64'h1);
    cyc();
    bus.sdram_finished = 1'b0;
    #2;
    chk("ab_idle", 64'(bus.sdram_read), 64'h0);

`ifdef ARB_TIMEOUT_EN
    // watchdog: requester 2 never finishes, requester 0 waits behind it
    cyc();
    bus.req_read = 3'b101;
    #2;
    for (int b = 1; b <= 8; b++) begin
      cyc();
      #2;
      chk($sformatf("to_grant_b%0d", b), 64'(bus.grant), 64'h4);
      chk($sformatf("to_terr_b%0d", b), 64'(bus.timeout_err), 64'(b == 8));
      chk($sformatf("to_fin_b%0d", b), 64'(bus.req_finished), 64'h0);
    end
    cyc();
    #2;
    chk("to_bubble_grant", 64'(bus.grant), 64'h0);
    chk("to_bubble_read", 64'(bus.sdram_read), 64'h0);
    chk("to_bubble_terr", 64'(bus.timeout_err), 64'h0);
    cyc();
    bus.req_read = 3'b001;
    #2;
    chk("to_next_grant", 64'(bus.grant), 64'h1);
    bus.sdram_finished = 1'b1;
    #1;
    chk("to_next_fin", 64'(bus.req_finished), 64'h1);
    cyc();
    bus.sdram_finished = 1'b0;
    bus.req_read       = 3'b000;
    #2;
`else
    // no watchdog: BUSY holds well beyond the TIMEOUT value
    cyc();
    bus.req_read = 3'b100;
    #2;
    for (int b = 1; b <= 12; b++) begin
      cyc();
      #2;
      chk($sformatf("nw_grant_b%0d", b), 64'(bus.grant), 64'h4);
      chk($sformatf("nw_read_b%0d", b), 64'(bus.sdram_read), 64'h1);
      chk($sformatf("nw_terr_b%0d", b), 64'(bus.timeout_err), 64'h0);
    end
    bus.sdram_finished = 1'b1;
    #1;
    chk("nw_fin", 64'(bus.req_finished), 64'h4);
    cyc();
    bus.sdram_finished = 1'b0;
    bus.req_read       = 3'b000;
    #2;
`endif
    chk("pre_rst_idle", 64'(bus.grant), 64'h0);

    // asynchronous reset mid-BUSY
    cyc();
    bus.req_read = 3'b010;
    #2;
    cyc();
    #2;
    chk("mr_busy", 64'(bus.sdram_read), 64'h1);
    chk("mr_grant", 64'(bus.grant), 64'h2);
    #1;
    i_rst_n      = 1'b0;
    bus.req_read = 3'b011;
    #1;
    chk("mr_read_async", 64'(bus.sdram_read), 64'h0);
    chk("mr_grant_async", 64'(bus.grant), 64'h0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc();
    #2;
    chk("mr_first_grant", 64'(bus.grant), 64'h1);
    chk("mr_first_read", 64'(bus.sdram_read), 64'h1);
    chk("mr_first_addr", 64'(bus.sdram_addr), 64'h000100);
    bus.sdram_finished = 1'b1;
    #1;
    chk("mr_fin", 64'(bus.req_finished), 64'h1);
    cyc();
    bus.sdram_finished = 1'b0;
    bus.req_read       = 3'b000;
    #2;
    chk("mr_end_idle", 64'(bus.grant), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM user port between up to NUM_REQ audio cores, e.g. req 0 = mix core, req 1 = record core, req 2 = playback core.
- Each requester uses the team's SDRAM handshake: hold read or write high with a stable address until a one-cycle finished pulse arrives.
- Grants are round-robin, one transaction per grant.
- The command is latched at grant, so a requester that aborts mid-transaction cannot corrupt the SDRAM bus.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 23: SDRAM word-address width.
- DATA_W, 32: data width.
- TIMEOUT, 1024: watchdog cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- req_read  in  NUM_REQ  per-requester read request.
- req_write  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ x ADDR_W  per-requester address.
- req_writedata  in  NUM_REQ x DATA_W  per-requester write data.
- req_readdata  out  DATA_W  read data, broadcast to all requesters.
- req_finished  out  NUM_REQ  one-hot completion pulse.
- grant  out  NUM_REQ  one-hot registered owner; 0 when idle.
- sdram_read  out  1  read command to SDRAM controller.
- sdram_write  out  1  write command to SDRAM controller.
- sdram_addr  out  ADDR_W  address to SDRAM controller.
- sdram_writedata  out  DATA_W  write data to SDRAM controller.
- sdram_readdata  in  DATA_W  read data from SDRAM controller.
- sdram_finished  in  1  SDRAM completion pulse.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (i_rst_n low, async): state=IDLE, grant=0, last pointer=NUM_REQ-1, all outputs 0, latched command registers 0.
- A requester is pending when req_read[i] | req_write[i].
- Having read and write both high is illegal; the arbiter treats it as a write.
- State IDLE:
  - sdram_read/write=0.
  - If any request is pending, pick the first pending index searching from last+1 upward, with modulo wrap.
  - Register grant=onehot(idx), last=idx, cmd_addr/cmd_wdata/cmd_is_write from that requester, then go to BUSY.
  - With no request pending, stay in IDLE.
- State BUSY:
  - sdram_read=!cmd_is_write, sdram_write=cmd_is_write.
  - sdram_addr=cmd_addr, sdram_writedata=cmd_wdata, all driven from the latched registers.
  - req_readdata=sdram_readdata combinationally, in every state.
  - req_finished[idx]=sdram_finished combinationally, in the same cycle.
  - On sdram_finished: go to IDLE, grant=0.
- Latency:
  - Request seen in IDLE at cycle T: the SDRAM command is asserted at T+1.
  - finished at cycle F: the next grant is registered at F+1, and its command is asserted at F+2.
  - There is exactly one idle bubble between transactions. This bubble lets a requester update its address before re-arbitration.
- Fairness: a requester that re-requests immediately after its finish is skipped if any other requester is pending. Worst-case wait is NUM_REQ-1 transactions.
- Requester drops its request while in BUSY (e.g. mix stop): ignored. The latched command completes, and the finished pulse is still issued to that index.
- sdram_finished while in IDLE: ignored; no req_finished is issued.
- Reset asserted mid-BUSY: everything returns to reset values immediately; the command deasserts asynchronously.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT-1 without sdram_finished, the arbiter deasserts the command, pulses timeout_err for 1 cycle, and returns to IDLE.
  - No req_finished is issued on abort.
  - last advances normally, so the offender is not regranted first.
  - If finished arrives in the same cycle as the limit, finished wins.
- Undefined: no counter is built, timeout_err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - the ADDR_W/DATA_W defaults;
  - the function onehot(idx).
- Sub-module rr_picker (combinational round-robin finder, parameter NUM_REQ):
  - inputs: pending vector and last index;
  - outputs: valid and idx.
  - It is instantiated once.

Test Plan:
- Single read: req_read[0]=1, addr=0x000100. Expect sdram_read and addr=0x000100 one cycle later. Finished is pulsed 3 cycles later with readdata=0xDEADBEEF. Expect req_finished=3'b001 and req_readdata=0xDEADBEEF in the same cycle.
- Round-robin: all three request continuously with finished after 2 BUSY cycles. Expect grant sequence 001,010,100,001, each separated by one grant=0 bubble.
- Write latching: req_write[2]=1, addr=0x7FFFFF, wdata=0x12345678. Change the addr/wdata inputs during BUSY. Expect sdram_addr/writedata to stay at the latched values until finished.
- Abort: requester 0 drops req_read mid-BUSY. Expect sdram_read to stay 1 until finished, then req_finished[0] to pulse.
- Reset mid-BUSY: pull i_rst_n low asynchronously between clock edges. Expect sdram_read=0, grant=0 without waiting for a clock edge. After release, requester 0 is granted first.
- ARB_TIMEOUT_EN, TIMEOUT=8: never assert finished. Expect timeout_err high in the 8th BUSY cycle, the command to drop, and the next pending requester to be granted after one bubble.
